// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the D/E/M pipeline stages and the hazard controller.
// The master drives stage information; the slave (hazard controller) returns control.
interface pipeline_hazard_ctrl_if;
  // D-stage operand usage
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic        D_md_use;
  // In-flight producers in E and M
  logic [4:0]  E_dst;
  logic [4:0]  M_dst;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  // Mult/div issue
  logic        md_start;
  logic        md_is_div;
  // Control back to the pipeline
  logic        stall;
  logic        pc_en;
  logic        fd_en;
  logic        de_clr;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        md_busy;
  logic [31:0] stall_cnt;
  // Debug view of the mult/div busy counter
  logic [3:0]  md_cnt_dbg;

  modport master (
    output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md_use,
    output E_dst, M_dst, E_tnew, M_tnew,
    output md_start, md_is_div,
    input  stall, pc_en, fd_en, de_clr,
    input  fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt, md_cnt_dbg
  );

  modport slave (
    input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md_use,
    input  E_dst, M_dst, E_tnew, M_tnew,
    input  md_start, md_is_div,
    output stall, pc_en, fd_en, de_clr,
    output fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt, md_cnt_dbg
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/forward decision for a 5-stage pipeline using tuse/tnew timing,
// plus the mult/div busy interlock and a stalled-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  // md_start is a single-cycle issue pulse with no backpressure: the unit
  // accepts it unconditionally and any running operation is restarted.

  logic [3:0]  md_cnt_q;
  logic [3:0]  md_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic        rs_haz;
  logic        rt_haz;
  logic        md_busy;
  logic        stall;

  // A producer blocks the operand only if its result arrives after the consumer needs it.
  function automatic logic hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (src == e_dst) && (tuse < e_tnew);
    m_hit = (src == m_dst) && (tuse < m_tnew);
    return (src != 5'd0) && (tuse != 2'd3) && (e_hit || m_hit);
  endfunction

  // E is the younger producer, so its value wins over M.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0 && src == e_dst && e_tnew == 2'd0) begin
      sel = 2'd1;
    end else if (src != 5'd0 && src == m_dst && m_tnew == 2'd0) begin
      sel = 2'd2;
    end
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (bus.md_start) begin
      md_cnt_d = bus.md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  // Output logic
  always_comb begin
    rs_haz  = hazard(bus.D_rs, bus.D_rs_tuse, bus.E_dst, bus.E_tnew, bus.M_dst, bus.M_tnew);
    rt_haz  = hazard(bus.D_rt, bus.D_rt_tuse, bus.E_dst, bus.E_tnew, bus.M_dst, bus.M_tnew);
    md_busy = (md_cnt_q != 4'd0) || bus.md_start;
    stall   = rs_haz || rt_haz || (bus.D_md_use && md_busy);

    bus.stall      = stall;
    bus.pc_en      = ~stall;
    bus.fd_en      = ~stall;
    bus.de_clr     = stall;
    bus.fwd_rs_sel = fwd_sel(bus.D_rs, bus.E_dst, bus.E_tnew, bus.M_dst, bus.M_tnew);
    bus.fwd_rt_sel = fwd_sel(bus.D_rt, bus.E_dst, bus.E_tnew, bus.M_dst, bus.M_tnew);
    bus.md_busy    = md_busy;
    bus.stall_cnt  = stall_cnt_q;
    bus.md_cnt_dbg = md_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the combinational
// decisions plus hand-written sequences for the mult/div busy period and reset.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [31:0] exp_q[$];

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock/reset
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic       md_use;
    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic       exp_stall;
    logic [1:0] exp_fwd_rs;
    logic [1:0] exp_fwd_rt;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [1:0] rs_tuse,
    input logic [4:0] rt, input logic [1:0] rt_tuse,
    input logic md_use,
    input logic [4:0] e_dst, input logic [1:0] e_tnew,
    input logic [4:0] m_dst, input logic [1:0] m_tnew,
    input logic exp_stall, input logic [1:0] exp_fwd_rs, input logic [1:0] exp_fwd_rt
  );
    vec_t v;
    v.rs = rs; v.rs_tuse = rs_tuse; v.rt = rt; v.rt_tuse = rt_tuse;
    v.md_use = md_use; v.e_dst = e_dst; v.e_tnew = e_tnew;
    v.m_dst = m_dst; v.m_tnew = m_tnew;
    v.exp_stall = exp_stall; v.exp_fwd_rs = exp_fwd_rs; v.exp_fwd_rt = exp_fwd_rt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    bus.D_rs = 5'd0; bus.D_rt = 5'd0; bus.D_rs_tuse = 2'd0; bus.D_rt_tuse = 2'd0;
    bus.D_md_use = 1'b0; bus.E_dst = 5'd0; bus.M_dst = 5'd0;
    bus.E_tnew = 2'd0; bus.M_tnew = 2'd0; bus.md_start = 1'b0; bus.md_is_div = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.D_rs = v.rs; bus.D_rt = v.rt; bus.D_rs_tuse = v.rs_tuse; bus.D_rt_tuse = v.rt_tuse;
    bus.D_md_use = v.md_use; bus.E_dst = v.e_dst; bus.E_tnew = v.e_tnew;
    bus.M_dst = v.m_dst; bus.M_tnew = v.m_tnew; bus.md_start = 1'b0; bus.md_is_div = 1'b0;
  endtask

  // Scoreboard: predict stall_cnt after the coming edge, then compare it.
  task automatic step(input logic exp_stall, input string name);
    if (reset) model_cnt = 32'd0;
    else if (exp_stall) model_cnt = model_cnt + 32'd1;
    exp_q.push_back(model_cnt);
    @(posedge clk);
    #1;
    check({name, "_stall_cnt"}, bus.stall_cnt, exp_q.pop_front());
  endtask

  task automatic check_ctrl(input string name, input logic exp_stall,
                            input logic [1:0] exp_rs, input logic [1:0] exp_rt);
    check({name, "_stall"},  {31'd0, bus.stall},  {31'd0, exp_stall});
    check({name, "_pc_en"},  {31'd0, bus.pc_en},  {31'd0, ~exp_stall});
    check({name, "_fd_en"},  {31'd0, bus.fd_en},  {31'd0, ~exp_stall});
    check({name, "_de_clr"}, {31'd0, bus.de_clr}, {31'd0, exp_stall});
    check({name, "_fwd_rs"}, {30'd0, bus.fwd_rs_sel}, {30'd0, exp_rs});
    check({name, "_fwd_rt"}, {30'd0, bus.fwd_rt_sel}, {30'd0, exp_rt});
  endtask

  initial begin
    //                rs tu  rt tu  md  edst tn  mdst tn  stall frs frt
    vecs[0]  = mk(5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    vecs[1]  = mk(5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0);
    vecs[2]  = mk(5'd0, 2'd0, 5'd8, 2'd1, 1'b0, 5'd8, 2'd0, 5'd8, 2'd0, 1'b0, 2'd0, 2'd1);
    vecs[3]  = mk(5'd0, 2'd0, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 1'b0, 2'd0, 2'd2);
    vecs[4]  = mk(5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    vecs[5]  = mk(5'd7, 2'd3, 5'd0, 2'd0, 1'b0, 5'd7, 2'd2, 5'd7, 2'd1, 1'b0, 2'd0, 2'd0);
    vecs[6]  = mk(5'd9, 2'd0, 5'd0, 2'd0, 1'b0, 5'd9, 2'd0, 5'd9, 2'd1, 1'b1, 2'd1, 2'd0);
    vecs[7]  = mk(5'd0, 2'd0, 5'd3, 2'd1, 1'b0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    vecs[8]  = mk(5'd0, 2'd0, 5'd12, 2'd0, 1'b0, 5'd0, 2'd0, 5'd12, 2'd1, 1'b1, 2'd0, 2'd0);
    vecs[9]  = mk(5'd4, 2'd0, 5'd6, 2'd0, 1'b0, 5'd4, 2'd0, 5'd6, 2'd0, 1'b0, 2'd1, 2'd2);
    vecs[10] = mk(5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0);

    // Reset state
    drive_idle();
    reset = 1'b1;
    step(1'b0, "rst0");
    step(1'b0, "rst1");
    reset = 1'b0;
    @(negedge clk);
    check_ctrl("reset", 1'b0, 2'd0, 2'd0);
    check("reset_md_busy", {31'd0, bus.md_busy}, 32'd0);
    check("reset_md_cnt", {28'd0, bus.md_cnt_dbg}, 32'd0);
    step(1'b0, "reset");

    // Combinational decision table
    for (int i = 0; i < NVEC; i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      check_ctrl($sformatf("v%0d", i), vecs[i].exp_stall, vecs[i].exp_fwd_rs, vecs[i].exp_fwd_rt);
      step(vecs[i].exp_stall, $sformatf("v%0d", i));
    end

    // Div busy period: start pulse, then D_md_use held for the busy window
    drive_idle();
    reset = 1'b1;
    step(1'b0, "div_rst");
    reset = 1'b0;
    bus.md_start = 1'b1;
    bus.md_is_div = 1'b1;
    @(negedge clk);
    check("div_start_busy", {31'd0, bus.md_busy}, 32'd1);
    check("div_start_stall", {31'd0, bus.stall}, 32'd0);
    step(1'b0, "div_start");
    check("div_load", {28'd0, bus.md_cnt_dbg}, 32'd10);
    bus.md_start = 1'b0;
    bus.D_md_use = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("div_busy%0d_stall", k), {31'd0, bus.stall}, 32'd1);
      step(1'b1, $sformatf("div_busy%0d", k));
    end
    @(negedge clk);
    check("div_done_stall", {31'd0, bus.stall}, 32'd0);
    check("div_done_busy", {31'd0, bus.md_busy}, 32'd0);
    check("div_total", bus.stall_cnt, 32'd10);
    step(1'b0, "div_done");

    // Mult restart mid-operation, then reset while busy
    drive_idle();
    bus.D_md_use = 1'b1;
    bus.md_start = 1'b1;
    step(1'b1, "mul_a");
    check("mul_load", {28'd0, bus.md_cnt_dbg}, 32'd5);
    bus.md_start = 1'b0;
    step(1'b1, "mul_b");
    check("mul_dec", {28'd0, bus.md_cnt_dbg}, 32'd4);
    bus.md_start = 1'b1;
    step(1'b1, "mul_c");
    check("mul_reload", {28'd0, bus.md_cnt_dbg}, 32'd5);
    bus.md_start = 1'b0;
    step(1'b1, "mul_d");
    step(1'b1, "mul_e");
    check("mul_at3", {28'd0, bus.md_cnt_dbg}, 32'd3);
    reset = 1'b1;
    step(1'b1, "mul_rst");
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, bus.md_busy}, 32'd0);
    check("post_rst_cnt", bus.stall_cnt, 32'd0);
    check("post_rst_md_cnt", {28'd0, bus.md_cnt_dbg}, 32'd0);
    check("post_rst_stall", {31'd0, bus.stall}, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
